// File: rtl/pat_sched_pkg.sv
// Shared types and pattern-number arithmetic for the pattern scheduler.
// Every helper compares before it steps, so 8-bit values never wrap past 0 or 255.
package pat_sched_pkg;

  localparam int PAT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic [PAT_W-1:0] pat_up(input logic [PAT_W-1:0] cur,
                                              input logic [PAT_W-1:0] pmax);
    logic [PAT_W-1:0] res;
    if (cur >= pmax) begin
      res = cur;
    end else begin
      res = cur + PAT_W'(1);
    end
    return res;
  endfunction

  // The top pattern is a lock-out end point: stepping down from it is refused.
  function automatic logic [PAT_W-1:0] pat_down(input logic [PAT_W-1:0] cur,
                                                input logic [PAT_W-1:0] pmin,
                                                input logic [PAT_W-1:0] pmax);
    logic [PAT_W-1:0] res;
    if ((cur >= pmax) || (cur <= pmin)) begin
      res = cur;
    end else begin
      res = cur - PAT_W'(1);
    end
    return res;
  endfunction

  function automatic logic [PAT_W-1:0] pat_wrap(input logic [PAT_W-1:0] cur,
                                                input logic [PAT_W-1:0] pmin,
                                                input logic [PAT_W-1:0] pmax);
    logic [PAT_W-1:0] res;
    if (cur >= pmax) begin
      res = pmin;
    end else begin
      res = cur + PAT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/pat_sched_tick_gen.sv
// Free-running us/ms/s tick chain; each tick is a registered one-cycle pulse.
// Also meant for reuse by the button debouncers.
module pat_sched_tick_gen #(
  parameter int CNT1US = 81,
  parameter int CNT1MS = 1000,
  parameter int CNT1S  = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_us_tick,
  output logic o_ms_tick,
  output logic o_s_tick
);

  localparam int US_W = (CNT1US > 1) ? $clog2(CNT1US) : 1;
  localparam int MS_W = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;
  localparam int S_W  = (CNT1S  > 1) ? $clog2(CNT1S)  : 1;
  localparam logic [US_W-1:0] US_LAST = US_W'(CNT1US - 1);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(CNT1MS - 1);
  localparam logic [S_W-1:0]  S_LAST  = S_W'(CNT1S - 1);

  logic [US_W-1:0] r_us_cnt;
  logic [MS_W-1:0] r_ms_cnt;
  logic [S_W-1:0]  r_s_cnt;
  logic            r_us_tick;
  logic            r_ms_tick;
  logic            r_s_tick;
  logic            w_us_wrap;
  logic            w_ms_wrap;
  logic            w_s_wrap;

  // Terminal-count decode for each stage of the chain.
  always_comb begin
    w_us_wrap = (r_us_cnt == US_LAST);
    w_ms_wrap = w_us_wrap && (r_ms_cnt == MS_LAST);
    w_s_wrap  = w_ms_wrap && (r_s_cnt == S_LAST);
  end

  // Cascaded counters; each stage advances only on the wrap of the stage below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_us_cnt <= '0;
      r_ms_cnt <= '0;
      r_s_cnt  <= '0;
    end else begin
      r_us_cnt <= w_us_wrap ? '0 : r_us_cnt + US_W'(1);
      if (w_ms_wrap) begin
        r_ms_cnt <= '0;
      end else if (w_us_wrap) begin
        r_ms_cnt <= r_ms_cnt + MS_W'(1);
      end else begin
        r_ms_cnt <= r_ms_cnt;
      end
      if (w_s_wrap) begin
        r_s_cnt <= '0;
      end else if (w_ms_wrap) begin
        r_s_cnt <= r_s_cnt + S_W'(1);
      end else begin
        r_s_cnt <= r_s_cnt;
      end
    end
  end

  // Registered tick pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_us_tick <= 1'b0;
      r_ms_tick <= 1'b0;
      r_s_tick  <= 1'b0;
    end else begin
      r_us_tick <= w_us_wrap;
      r_ms_tick <= w_ms_wrap;
      r_s_tick  <= w_s_wrap;
    end
  end

  assign o_us_tick = r_us_tick;
  assign o_ms_tick = r_ms_tick;
  assign o_s_tick  = r_s_tick;

endmodule

// File: rtl/pat_sched.sv
// Pattern scheduler: manual/auto events move a target pattern, which is
// committed to pat_sn on a frame boundary or, failing that, after a timeout.
module pat_sched
  import pat_sched_pkg::*;
#(
  parameter int               CNT1US    = 81,
  parameter int               CNT1MS    = 1000,
  parameter int               CNT1S     = 1000,
  parameter logic [PAT_W-1:0] PATMIN    = 8'd127,
  parameter logic [PAT_W-1:0] PATMAX    = 8'd255,
  parameter int               DWELL_S   = 3,
  parameter int               FRM_TO_MS = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_evt,
  input  logic             down_evt,
  input  logic             auto_evt,
  input  logic             lock,
  input  logic             frm_sync,
  output logic [PAT_W-1:0] pat_sn,
  output logic             pat_chg,
  output logic             pend,
  output logic             auto_on,
  output logic             sync_err
);

  localparam int DW_W = (DWELL_S > 1) ? $clog2(DWELL_S) : 1;
  localparam int TO_W = $clog2(FRM_TO_MS + 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_S - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FRM_TO_MS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PAT_W-1:0] r_target;
  logic [PAT_W-1:0] w_target_nxt;
  logic [PAT_W-1:0] r_pat_sn;
  logic [DW_W-1:0]  r_dwell;
  logic [TO_W-1:0]  r_frm_to;
  logic             r_pat_chg;
  logic             r_pend;
  logic             r_auto_on;
  logic             r_sync_err;
  logic             w_unused_us_tick;
  logic             w_ms_tick;
  logic             w_s_tick;
  logic             w_manual;
  logic             w_auto_tgl;
  logic             w_auto_exp;
  logic             w_same;
  logic             w_timeout;
  logic             w_commit;
  logic             w_chg;
  logic             w_force;
  logic             w_pend_nxt;

  pat_sched_tick_gen #(
    .CNT1US (CNT1US),
    .CNT1MS (CNT1MS),
    .CNT1S  (CNT1S)
  ) u_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .o_us_tick (w_unused_us_tick),
    .o_ms_tick (w_ms_tick),
    .o_s_tick  (w_s_tick)
  );

  // Event qualification; lock masks every scheduling event.
  always_comb begin
    w_manual   = !lock && (up_evt || down_evt);
    w_auto_tgl = !lock && auto_evt;
    w_auto_exp = !lock && r_auto_on && (r_state == IDLE) && w_s_tick && (r_dwell == DW_LAST);
    w_same     = (r_target == r_pat_sn);
    w_timeout  = w_ms_tick && (r_frm_to == TO_LAST);
  end

  // Target update with priority up > down > auto expiry.
  always_comb begin
    w_target_nxt = r_target;
    if (lock) begin
      w_target_nxt = r_target;
    end else if (up_evt) begin
      w_target_nxt = pat_up(r_target, PATMAX);
    end else if (down_evt) begin
      w_target_nxt = pat_down(r_target, PATMIN, PATMAX);
    end else if (w_auto_exp) begin
      w_target_nxt = pat_wrap(r_target, PATMIN, PATMAX);
    end else begin
      w_target_nxt = r_target;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; a target that returns to pat_sn abandons the commit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_same) begin
          w_state_nxt = PEND;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PEND: begin
        if (w_same) begin
          w_state_nxt = IDLE;
        end else if (frm_sync || w_timeout) begin
          w_state_nxt = COMMIT;
        end else begin
          w_state_nxt = PEND;
        end
      end
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs, registered below.
  always_comb begin
    w_commit   = (r_state == COMMIT);
    w_chg      = w_commit && !w_same;
    w_force    = (r_state == PEND) && !w_same && !frm_sync && w_timeout;
    w_pend_nxt = (w_state_nxt != IDLE);
  end

  // Committed pattern, status flags and target register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target   <= PATMIN;
      r_pat_sn   <= PATMIN;
      r_pat_chg  <= 1'b0;
      r_pend     <= 1'b0;
      r_auto_on  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_target   <= w_target_nxt;
      r_pat_sn   <= w_commit ? r_target : r_pat_sn;
      r_pat_chg  <= w_chg;
      r_pend     <= w_pend_nxt;
      r_auto_on  <= r_auto_on ^ w_auto_tgl;
      r_sync_err <= r_sync_err | w_force;
    end
  end

  // Dwell counts seconds in IDLE; the frame timeout counts ms while pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell  <= '0;
      r_frm_to <= '0;
    end else begin
      if (w_commit || w_manual || w_auto_tgl || w_auto_exp) begin
        r_dwell <= '0;
      end else if (!lock && r_auto_on && (r_state == IDLE) && w_s_tick) begin
        r_dwell <= r_dwell + DW_W'(1);
      end else begin
        r_dwell <= r_dwell;
      end
      if (r_state != PEND) begin
        r_frm_to <= '0;
      end else if (w_ms_tick) begin
        r_frm_to <= r_frm_to + TO_W'(1);
      end else begin
        r_frm_to <= r_frm_to;
      end
    end
  end

  assign pat_sn   = r_pat_sn;
  assign pat_chg  = r_pat_chg;
  assign pend     = r_pend;
  assign auto_on  = r_auto_on;
  assign sync_err = r_sync_err;

endmodule

// File: tb/tb_pat_sched.sv
// Directed bench for pat_sched with short timing parameters (1 s = 8 clk).
module tb_pat_sched;

  logic       clk;
  logic       rst_n;
  logic       up_evt;
  logic       down_evt;
  logic       auto_evt;
  logic       lock;
  logic       frm_sync;
  logic [7:0] pat_sn;
  logic       pat_chg;
  logic       pend;
  logic       auto_on;
  logic       sync_err;

  int n_chk;
  int n_err;
  int n_chg;
  int base;
  int el;
  bit found;

  pat_sched #(
    .CNT1US    (2),
    .CNT1MS    (2),
    .CNT1S     (2),
    .PATMIN    (8'd127),
    .PATMAX    (8'd255),
    .DWELL_S   (2),
    .FRM_TO_MS (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_evt   (up_evt),
    .down_evt (down_evt),
    .auto_evt (auto_evt),
    .lock     (lock),
    .frm_sync (frm_sync),
    .pat_sn   (pat_sn),
    .pat_chg  (pat_chg),
    .pend     (pend),
    .auto_on  (auto_on),
    .sync_err (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pat_chg === 1'b1) n_chg <= n_chg + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_commit;
    int k;
    k = 0;
    while (pend !== 1'b1 && k < 6) begin
      step;
      k++;
    end
    check_val("commit_pend", int'(pend), 1);
    frm_sync = 1'b1;
    step;
    frm_sync = 1'b0;
    step;
  endtask

  task automatic climb(input int n);
    for (int i = 0; i < n; i++) begin
      up_evt   = 1'b1;
      frm_sync = (i % 3 == 0);
      step;
    end
    up_evt   = 1'b0;
    frm_sync = 1'b1;
    repeat (6) step;
    frm_sync = 1'b0;
    step;
    step;
  endtask

  task automatic pulse_up;
    up_evt = 1'b1;
    step;
    up_evt = 1'b0;
    step;
  endtask

  initial begin
    n_chk = 0; n_err = 0; n_chg = 0;
    rst_n = 1'b0; up_evt = 1'b0; down_evt = 1'b0; auto_evt = 1'b0;
    lock = 1'b0; frm_sync = 1'b0;
    repeat (3) step;
    check_val("rst_pat_sn", int'(pat_sn), 127);
    check_val("rst_pend", int'(pend), 0);
    check_val("rst_pat_chg", int'(pat_chg), 0);
    check_val("rst_auto_on", int'(auto_on), 0);
    check_val("rst_sync_err", int'(sync_err), 0);
    rst_n = 1'b1;
    step;

    // three ups, commit only on frm_sync; pend latency N+2
    up_evt = 1'b1;
    step;
    check_val("t1_pend_n1", int'(pend), 0);
    step;
    check_val("t1_pend_n2", int'(pend), 1);
    step;
    up_evt = 1'b0;
    repeat (3) step;
    check_val("t1_hold_pat_sn", int'(pat_sn), 127);
    frm_sync = 1'b1;
    step;
    frm_sync = 1'b0;
    check_val("t1_m1_pat_chg", int'(pat_chg), 0);
    check_val("t1_m1_pat_sn", int'(pat_sn), 127);
    step;
    check_val("t1_pat_sn", int'(pat_sn), 130);
    check_val("t1_pat_chg", int'(pat_chg), 1);
    check_val("t1_pend", int'(pend), 0);
    step;
    check_val("t1_chg_single", int'(pat_chg), 0);
    check_val("t1_sync_err", int'(sync_err), 0);

    // climb to 254, saturate at 255, down refused at 255
    climb(124);
    check_val("t2_pat_sn_254", int'(pat_sn), 254);
    check_val("t2_sync_err", int'(sync_err), 0);
    pulse_up; pulse_up; pulse_up;
    do_commit;
    check_val("t2_pat_sn_255", int'(pat_sn), 255);
    check_val("t2_pat_chg", int'(pat_chg), 1);
    down_evt = 1'b1;
    step;
    down_evt = 1'b0;
    base = n_chg;
    frm_sync = 1'b1;
    step;
    frm_sync = 1'b0;
    step;
    step;
    check_val("t2_down_pat_sn", int'(pat_sn), 255);
    check_val("t2_down_pend", int'(pend), 0);
    check_val("t2_down_nochg", n_chg, base);

    // auto mode from 254: advance to 255, then wrap to 127
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    climb(127);
    check_val("t3_pat_sn_254", int'(pat_sn), 254);
    auto_evt = 1'b1;
    step;
    auto_evt = 1'b0;
    check_val("t3_auto_on", int'(auto_on), 1);
    found = 1'b0; el = 0;
    for (int c = 1; c <= 40 && !found; c++) begin
      frm_sync = (c % 3 == 0);
      step;
      if (pat_chg === 1'b1) begin found = 1'b1; el = c; end
    end
    frm_sync = 1'b0;
    check_val("t3_adv_seen", int'(found), 1);
    check_val("t3_adv_pat_sn", int'(pat_sn), 255);
    check_val("t3_adv_not_early", int'(el >= 10), 1);
    check_val("t3_adv_not_late", int'(el <= 24), 1);
    found = 1'b0; el = 0;
    for (int c = 1; c <= 40 && !found; c++) begin
      frm_sync = (c % 3 == 0);
      step;
      if (pat_chg === 1'b1) begin found = 1'b1; el = c; end
    end
    frm_sync = 1'b0;
    check_val("t3_wrap_seen", int'(found), 1);
    check_val("t3_wrap_pat_sn", int'(pat_sn), 127);
    check_val("t3_wrap_not_early", int'(el >= 9), 1);
    check_val("t3_wrap_auto_on", int'(auto_on), 1);
    auto_evt = 1'b1;
    step;
    auto_evt = 1'b0;
    check_val("t3_auto_off", int'(auto_on), 0);

    // up wins over down; up-then-down cancels without a commit
    pulse_up; pulse_up; pulse_up;
    do_commit;
    check_val("t4_pat_sn_130", int'(pat_sn), 130);
    up_evt = 1'b1; down_evt = 1'b1;
    step;
    up_evt = 1'b0; down_evt = 1'b0;
    do_commit;
    check_val("t4_up_wins", int'(pat_sn), 131);
    up_evt = 1'b1;
    step;
    up_evt = 1'b0;
    down_evt = 1'b1;
    base = n_chg;
    step;
    down_evt = 1'b0;
    check_val("t4_cancel_pend_hi", int'(pend), 1);
    step;
    check_val("t4_cancel_pend_lo", int'(pend), 0);
    repeat (3) step;
    check_val("t4_cancel_nochg", n_chg, base);
    check_val("t4_cancel_pat_sn", int'(pat_sn), 131);

    // frame-sync timeout forces the commit and sets sticky sync_err
    up_evt = 1'b1;
    step;
    up_evt = 1'b0;
    repeat (9) step;
    check_val("t5_no_early_commit", int'(pat_sn), 131);
    check_val("t5_pend", int'(pend), 1);
    check_val("t5_err_before", int'(sync_err), 0);
    found = 1'b0;
    for (int c = 1; c <= 25 && !found; c++) begin
      step;
      if (pat_chg === 1'b1) found = 1'b1;
    end
    check_val("t5_forced_seen", int'(found), 1);
    check_val("t5_forced_pat_sn", int'(pat_sn), 132);
    check_val("t5_sync_err", int'(sync_err), 1);
    pulse_up;
    do_commit;
    check_val("t5_next_pat_sn", int'(pat_sn), 133);
    check_val("t5_err_sticky", int'(sync_err), 1);
    step;
    check_val("t5_idle", int'(pend), 0);

    // lock in auto mode: dwell holds, remaining dwell finishes after release
    auto_evt = 1'b1;
    step;
    auto_evt = 1'b0;
    base = n_chg;
    check_val("t6_auto_on", int'(auto_on), 1);
    repeat (8) step;
    lock = 1'b1;
    for (int i = 0; i < 40; i++) begin
      up_evt   = (i % 5 == 0);
      auto_evt = (i % 13 == 3);
      frm_sync = 1'b1;
      step;
    end
    up_evt = 1'b0; auto_evt = 1'b0;
    check_val("t6_lock_pat_sn", int'(pat_sn), 133);
    check_val("t6_lock_nochg", n_chg, base);
    check_val("t6_lock_auto_on", int'(auto_on), 1);
    check_val("t6_lock_pend", int'(pend), 0);
    lock = 1'b0;
    found = 1'b0; el = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      step;
      if (pat_chg === 1'b1) begin found = 1'b1; el = k; end
    end
    frm_sync = 1'b0;
    check_val("t6_resume_seen", int'(found), 1);
    check_val("t6_resume_pat_sn", int'(pat_sn), 134);
    check_val("t6_resume_remaining", int'(el <= 11), 1);
    check_val("t6_resume_not_early", int'(el >= 4), 1);

    // asynchronous reset while pending
    up_evt = 1'b1;
    step;
    up_evt = 1'b0;
    base = n_chg;
    step;
    check_val("t7_pend_before", int'(pend), 1);
    rst_n = 1'b0;
    #1;
    check_val("t7_rst_pat_sn", int'(pat_sn), 127);
    check_val("t7_rst_pend", int'(pend), 0);
    check_val("t7_rst_auto_on", int'(auto_on), 0);
    check_val("t7_rst_sync_err", int'(sync_err), 0);
    check_val("t7_rst_pat_chg", int'(pat_chg), 0);
    repeat (3) step;
    rst_n = 1'b1;
    repeat (5) step;
    check_val("t7_after_nochg", n_chg, base);
    check_val("t7_after_pat_sn", int'(pat_sn), 127);
    check_val("t7_after_pend", int'(pend), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
